// File: rtl/imem_loader.sv
// Instruction-memory program loader: consumes a framed byte stream (length, program, XOR checksum)
// and writes it byte-by-byte from address 0, holding the CPU in stall until a good load completes.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

  state_t            state;
  state_t            state_next;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   n_bytes;
  logic              accept;
  logic [15:0]       n_words;
  logic [17:0]       len_full;
  logic              last_byte;

  always_comb begin
    in_ready   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                 (state == S_DATA)   || (state == S_CSUM);
    busy       = in_ready;
    done       = (state == S_DONE);
    error      = (state == S_ERR);
    cpu_hold   = (state != S_DONE);
    accept     = in_valid & in_ready;
    n_words    = {in_data, len_lo};
    len_full   = {n_words, 2'b00};
    last_byte  = ((cnt + 1'b1) == n_bytes);
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (n_words > MAX_WORDS)   state_next = S_ERR;
          else if (n_words == '0)    state_next = S_CSUM;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) state_next = S_CSUM;
      S_CSUM: if (accept) state_next = (in_data == csum) ? S_DONE : S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_lo   <= '0;
      csum     <= '0;
      cnt      <= '0;
      n_bytes  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err_code <= '0;
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) err_code <= '0;
        S_LEN_LO: if (accept) len_lo <= in_data;
        S_LEN_HI: begin
          if (accept) begin
            cnt     <= '0;
            csum    <= '0;
            // Only meaningful when the length check passes, so truncation is safe.
            n_bytes <= len_full[ADDR_W:0];
            if (n_words > MAX_WORDS) err_code <= 2'b01;
          end
        end
        S_DATA: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_W-1:0];
            wr_data <= in_data;
            csum    <= csum ^ in_data;
            cnt     <= cnt + 1'b1;
          end
        end
        S_CSUM: if (accept && (in_data != csum)) err_code <= 2'b10;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of framed loads, hand-written corner sequences and randomized
// frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = MEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic              cpu_hold;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         pat;       // 0 = nominal program, 1 = byte k = k[7:0], 2 = random
    int         n_words;
    bit         bad_csum;
    int         gap_pct;
    bit         exp_done;
    logic [1:0] exp_code;
    int         exp_writes;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  bit aborted;

  logic [7:0]        frame[$];
  logic [7:0]        exp_w[$];
  logic [ADDR_W-1:0] waddr[$];
  logic [7:0]        wdat[$];
  logic [7:0]        nom[8];

  always @(negedge clk) begin
    if (wr_en) begin
      waddr.push_back(wr_addr);
      wdat.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".wr_en"},    32'(wr_en),    0);
    chk({tag, ".wr_addr"},  32'(wr_addr),  0);
    chk({tag, ".wr_data"},  32'(wr_data),  0);
    chk({tag, ".busy"},     32'(busy),     0);
    chk({tag, ".done"},     32'(done),     0);
    chk({tag, ".error"},    32'(error),    0);
    chk({tag, ".err_code"}, 32'(err_code), 0);
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 1);
  endtask

  task automatic build(input int pat, input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] x;
    frame = {};
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    if (n > MAX_WORDS) return;
    x = 8'h00;
    for (int k = 0; k < 4 * n; k++) begin
      if (pat == 0)      b = nom[k % 8];
      else if (pat == 1) b = k[7:0];
      else               b = 8'($urandom);
      frame.push_back(b);
      x ^= b;
    end
    frame.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Frame-level reference: what a correct loader must write and report for the current frame.
  task automatic model(output bit d, output logic [1:0] c);
    int n;
    logic [7:0] x;
    exp_w = {};
    n = int'({frame[1], frame[0]});
    if (n > MAX_WORDS) begin
      d = 0; c = 2'b01;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < 4 * n; k++) begin
      exp_w.push_back(frame[2 + k]);
      x ^= frame[2 + k];
    end
    if (frame[2 + 4 * n] == x) begin d = 1; c = 2'b00; end
    else                       begin d = 0; c = 2'b10; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int budget;
    while ($urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      nvec++;
      nmis++;
      $display("FAIL handshake_timeout: in_ready 0 for 100 cycles, expected 1");
      aborted  = 1;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_pct, input int start_at);
    waddr.delete();
    wdat.delete();
    aborted = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_start.busy", 32'(busy), 1);
    chk("after_start.in_ready", 32'(in_ready), 1);
    for (int i = 0; i < frame.size() && !aborted; i++) begin
      if (i == start_at) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
      end
      send_byte(frame[i], gap_pct);
    end
  endtask

  task automatic check_result(input string tag, input bit d, input logic [1:0] c);
    int bad;
    chk({tag, ".done"},     32'(done),     32'(d));
    chk({tag, ".error"},    32'(error),    32'(!d));
    chk({tag, ".err_code"}, 32'(err_code), 32'(c));
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!d));
    chk({tag, ".busy"},     32'(busy),     0);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".wr_count"}, 32'(waddr.size()), 32'(exp_w.size()));
    bad = 0;
    for (int i = 0; i < waddr.size() && i < exp_w.size(); i++)
      if (waddr[i] !== i[ADDR_W-1:0] || wdat[i] !== exp_w[i]) bad++;
    chk({tag, ".wr_seq_errors"}, 32'(bad), 0);
  endtask

  task automatic idle_noise(input string tag, input bit d, input logic [1:0] c);
    int nw;
    nw = waddr.size();
    repeat (4) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, ".noise_writes"},   32'(waddr.size() - nw), 0);
    chk({tag, ".noise_done"},     32'(done),     32'(d));
    chk({tag, ".noise_err_code"}, 32'(err_code), 32'(c));
  endtask

  initial begin
    vec_t       vt[8];
    bit         md;
    logic [1:0] mc;
    int         n;
    int         sa;

    nom = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    vt[0] = '{"nominal",      0, 2,     0, 0,  1, 2'b00, 8};
    vt[1] = '{"bad_csum",     0, 2,     1, 0,  0, 2'b10, 8};
    vt[2] = '{"len_overflow", 2, 257,   0, 0,  0, 2'b01, 0};
    vt[3] = '{"len_ffff",     2, 65535, 0, 0,  0, 2'b01, 0};
    vt[4] = '{"empty",        2, 0,     0, 0,  1, 2'b00, 0};
    vt[5] = '{"full",         1, 256,   0, 0,  1, 2'b00, 1024};
    vt[6] = '{"backpressure", 0, 2,     0, 45, 1, 2'b00, 8};
    vt[7] = '{"rand_badcsum", 2, 5,     1, 20, 0, 2'b10, 20};

    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    for (int i = 0; i < 8; i++) begin
      build(vt[i].pat, vt[i].n_words, vt[i].bad_csum);
      model(md, mc);
      run_frame(vt[i].gap_pct, -1);
      chk({vt[i].name, ".exp_writes"}, 32'(exp_w.size()), 32'(vt[i].exp_writes));
      check_result(vt[i].name, vt[i].exp_done, vt[i].exp_code);
      if (vt[i].n_words == 256)
        chk("full.last_addr", 32'(waddr[waddr.size() - 1]), 1023);
      idle_noise(vt[i].name, vt[i].exp_done, vt[i].exp_code);
    end

    // start pulsed mid-DATA and mid-CSUM must be ignored
    build(0, 2, 0);
    model(md, mc);
    run_frame(0, 5);
    check_result("start_in_data", 1, 2'b00);
    run_frame(0, 10);
    check_result("start_in_csum", 1, 2'b00);

    // reset after three program bytes, with a handshake presented on the reset edge
    build(2, 2, 0);
    waddr.delete();
    wdat.delete();
    aborted = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(frame[i], 0);
    rst = 1'b1; in_valid = 1'b1; in_data = frame[5];
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_reset("mid_reset");
    repeat (4) @(negedge clk);
    chk("mid_reset.wr_count", 32'(waddr.size()), 3);
    chk("mid_reset.busy_later", 32'(busy), 0);
    build(0, 2, 0);
    model(md, mc);
    run_frame(0, -1);
    check_result("reload", 1, 2'b00);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) n = $urandom_range(MAX_WORDS + 1, 65535);
      else                           n = $urandom_range(0, 12);
      build(2, n, $urandom_range(0, 2) == 0);
      model(md, mc);
      sa = -1;
      if (n <= MAX_WORDS && $urandom_range(0, 1) == 1)
        sa = $urandom_range(2, frame.size() - 1);
      run_frame($urandom_range(0, 50), sa);
      check_result($sformatf("rand%0d", r), md, mc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the byte-addressed instruction memory: accepts a framed byte stream (length header, program bytes, XOR checksum) over a valid/ready handshake and writes it byte-by-byte, little-endian order preserved, into the instruction memory's write port starting at byte address 0. It holds the CPU in stall (`cpu_hold`) from reset until a load completes with a valid checksum, replacing the simulation-only hex preload for FPGA bring-up.

## Interface
Parameters:
- `MEM_BYTES`, 1024: instruction memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 10: byte address width, equal to log2(`MEM_BYTES`).

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: memory byte write strobe.
- `wr_addr` output ADDR_W: memory byte address.
- `wr_data` output 8: memory byte data.
- `busy` output 1: load in progress (LEN_LO, LEN_HI, DATA or CSUM).
- `done` output 1: last load succeeded.
- `error` output 1: last load failed.
- `err_code` output 2: 2'b01 = length too large; 2'b10 = checksum mismatch; 2'b00 = no error.
- `cpu_hold` output 1: CPU stall/reset request; high in every state except DONE.

## Operation
- A byte is accepted when `in_valid & in_ready` on a rising edge.
- `in_ready` is high only in LEN_LO, LEN_HI, DATA and CSUM. It is decoded from the registered state.
- Frame format: `len_lo`, `len_hi`, then 4*N program bytes, then the checksum byte. N = {len_hi, len_lo} is a word count. The checksum is the XOR of all program bytes; it is 0x00 when N = 0.
- States and transitions:
  - IDLE: go to LEN_LO on `start`.
  - LEN_LO: capture `len_lo`, go to LEN_HI.
  - LEN_HI: compute N.
    - N > MEM_BYTES/4: go to ERR with `err_code` = 01.
    - N = 0: go to CSUM.
    - Otherwise: go to DATA with the byte counter and running XOR cleared.
  - DATA: each accepted byte is XORed into the checksum and issued as a write. The counter increments. Leave for CSUM on acceptance of byte index 4N-1.
  - CSUM: on acceptance, go to DONE if the byte equals the running XOR, else go to ERR with `err_code` = 10.
  - DONE and ERR: hold their status until the next `start`. `start` clears `done`, `error` and `err_code`, then goes to LEN_LO.
- `start` while busy is ignored.
- `in_valid` outside the accepting states is ignored. No byte is consumed and nothing is recorded.
- Byte counter width is ADDR_W+1, so it can represent `MEM_BYTES`. `wr_addr` is the low ADDR_W bits of the counter. Wrap-around cannot occur because the length check prevents it.
- Byte k of the stream lands at address k. Word i is therefore assembled by the memory as {b[4i+3], b[4i+2], b[4i+1], b[4i]}.
- The loader never reads memory. Bytes already written stay in memory after ERR or reset.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `busy` = 0, `done` = 0, `error` = 0, `err_code` = 00.
  - `cpu_hold` = 1.
  - Counter and XOR = 0.
- Reset takes priority over every event, including a handshake in the same cycle.
- Reset mid-load aborts to IDLE. No further writes are issued.
- Write latency is 1 cycle: the byte accepted at edge t drives `wr_en` = 1, `wr_addr` and `wr_data` during the cycle after t. `wr_en` is high for exactly one cycle per program byte.
- Throughput is one byte per cycle. Gaps on `in_valid` simply stall; no timeout applies.
- `done` or `error` rises the cycle after the checksum byte is accepted. `cpu_hold` falls in that same cycle on success.
- The last `wr_en` occurs no later than the cycle in which CSUM is entered.
- A length error is flagged the cycle after `len_hi` is accepted, with zero writes.

## Test plan
- Nominal load:
  - Stimulus: `start`, then 02 00 | 13 00 00 00 93 00 10 00 | 90.
  - Required: 8 writes at addresses 0–7 with those bytes in order.
  - Required: `done` = 1, `cpu_hold` = 0 one cycle after the 0x90 byte.
- Bad checksum:
  - Stimulus: the same frame ending in 0x91.
  - Required: 8 writes, then `error` = 1, `err_code` = 10, `cpu_hold` = 1, `done` = 0.
- Length overflow:
  - Stimulus: 01 01 (N = 257) with `MEM_BYTES` = 1024.
  - Required: `err_code` = 01 one cycle after `len_hi`, no `wr_en`, `in_ready` = 0 afterwards.
- Empty and full loads:
  - Stimulus: 00 00 00.
  - Required: `done`, zero writes.
  - Stimulus: N = 256 with byte k = k[7:0] and checksum 0x00.
  - Required: 1024 writes, the last at `wr_addr` 1023, then `done`.
- Backpressure and ignored inputs:
  - Stimulus: `in_valid` randomly deasserted during the nominal frame.
  - Required: identical write sequence and result.
  - Stimulus: `start` pulsed during DATA.
  - Required: no effect.
- Reset mid-load and reload:
  - Stimulus: assert `rst` after 3 program bytes.
  - Required: next cycle all outputs at reset values.
  - Stimulus: `start` and the nominal frame again.
  - Required: writes restart at address 0 and end in `done`.
